axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_pkg.sv | 22 ++
 rtl/axi_sram_slave.sv | 185 ++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the single-beat SRAM slave: default widths,
// response codes and the controller state encoding.
package axi_pkg;

    localparam int AXI_IDW = 4;
    localparam int AXI_AW  = 32;
    localparam int AXI_DW  = 32;
    localparam int AXI_SW  = AXI_DW / 8;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_MEM  = 3'd1,
        RD_WAIT = 3'd2,
        RD_RESP = 3'd3,
        WR_DATA = 3'd4,
        WR_WAIT = 3'd5,
        WR_RESP = 3'd6
    } axi_state_t;

endpackage

// File: rtl/axi_sram_slave.sv
// Single-beat AXI slave in front of an external synchronous SRAM.
// One transaction in flight at a time; writes win over reads in IDLE.
// Optional macro AXI_SLV_DELAY_EN inserts RESP_DELAY extra cycles before
// rvalid/bvalid; without it the wait states and counter do not exist.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int MEM_AW     = 16,
    parameter int RESP_DELAY = 2
) (
    input  logic                clk,
    input  logic                resetn,
    // read address
    input  logic [AXI_IDW-1:0]  arid,
    input  logic [AXI_AW-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    // read data
    output logic [AXI_IDW-1:0]  rid,
    output logic [AXI_DW-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    // write address
    input  logic [AXI_IDW-1:0]  awid,
    input  logic [AXI_AW-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    // write data
    input  logic [AXI_IDW-1:0]  wid,
    input  logic [AXI_DW-1:0]   wdata,
    input  logic [AXI_SW-1:0]   wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    // write response
    output logic [AXI_IDW-1:0]  bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    // SRAM port
    output logic                ram_en,
    output logic [AXI_SW-1:0]   ram_wen,
    output logic [MEM_AW-1:0]   ram_addr,
    output logic [AXI_DW-1:0]   ram_wdata,
    input  logic [AXI_DW-1:0]   ram_rdata
);

    axi_state_t          r_state;
    axi_state_t          w_state_next;
    logic [AXI_IDW-1:0]  r_rid;
    logic [AXI_IDW-1:0]  r_bid;
    logic [MEM_AW-1:0]   r_addr;
    logic [AXI_DW-1:0]   r_rdata;
    logic                w_ar_hs;
    logic                w_aw_hs;
    logic                w_w_hs;

`ifdef AXI_SLV_DELAY_EN
    localparam logic [3:0] DELAY_LOAD = 4'(RESP_DELAY - 1);
    localparam bit         DELAY_NZ   = (RESP_DELAY != 0);
    logic [3:0] r_cnt;
    logic       w_delay_nz;
    assign w_delay_nz = DELAY_NZ;
`endif

    // Burst/size/id-of-W fields are ignored: every transfer is one beat.
    logic w_unused;
    assign w_unused = ^{arlen, arsize, arburst, awlen, awsize, awburst,
                        wid, wlast, araddr, awaddr
`ifndef AXI_SLV_DELAY_EN
                        , 4'(RESP_DELAY)
`endif
                        };

    // Next-state and SRAM/handshake decode; everything is held quiet in reset.
    always_comb begin
        w_state_next = r_state;
        awready      = 1'b0;
        arready      = 1'b0;
        wready       = 1'b0;
        ram_en       = 1'b0;
        ram_wen      = '0;
        ram_addr     = r_addr;
        ram_wdata    = wdata;
        w_ar_hs      = 1'b0;
        w_aw_hs      = 1'b0;
        w_w_hs       = 1'b0;
        if (!resetn) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    awready = 1'b1;
                    arready = !awvalid;
                    if (awvalid) begin
                        w_aw_hs      = 1'b1;
                        w_state_next = WR_DATA;
                    end else if (arvalid) begin
                        w_ar_hs      = 1'b1;
                        ram_en       = 1'b1;
                        ram_addr     = araddr[MEM_AW+1:2];
                        w_state_next = RD_MEM;
                    end
                end
                RD_MEM: begin
`ifdef AXI_SLV_DELAY_EN
                    w_state_next = w_delay_nz ? RD_WAIT : RD_RESP;
`else
                    w_state_next = RD_RESP;
`endif
                end
`ifdef AXI_SLV_DELAY_EN
                RD_WAIT: if (r_cnt == 4'd0) w_state_next = RD_RESP;
                WR_WAIT: if (r_cnt == 4'd0) w_state_next = WR_RESP;
`endif
                RD_RESP: if (rready) w_state_next = IDLE;
                WR_DATA: begin
                    wready = 1'b1;
                    if (wvalid) begin
                        w_w_hs  = 1'b1;
                        ram_en  = 1'b1;
                        ram_wen = wstrb;
`ifdef AXI_SLV_DELAY_EN
                        w_state_next = w_delay_nz ? WR_WAIT : WR_RESP;
`else
                        w_state_next = WR_RESP;
`endif
                    end
                end
                WR_RESP: if (bready) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State register plus captured ids, address and read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_rid   <= '0;
            r_bid   <= '0;
            r_addr  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_ar_hs) r_rid <= arid;
            if (w_aw_hs) begin
                r_bid  <= awid;
                r_addr <= awaddr[MEM_AW+1:2];
            end
            if (r_state == RD_MEM) r_rdata <= ram_rdata;
        end
    end

`ifdef AXI_SLV_DELAY_EN
    // Response delay counter: loaded as the wait begins, counts to zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state == RD_MEM || w_w_hs) begin
            r_cnt <= DELAY_LOAD;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end
`endif

    assign rvalid = resetn && (r_state == RD_RESP);
    assign bvalid = resetn && (r_state == WR_RESP);
    assign rid    = r_rid;
    assign bid    = r_bid;
    assign rdata  = r_rdata;
    assign rresp  = RESP_OKAY;
    assign bresp  = RESP_OKAY;
    assign rlast  = 1'b1;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave with a behavioural SRAM.
module tb_axi_sram_slave;

    localparam int MEM_AW = 16;
`ifdef AXI_SLV_DELAY_EN
    localparam int RD_LAT = 2 + 2;
    localparam int WR_LAT = 1 + 2;
`else
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = 2'b01;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b1;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [MEM_AW-1:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_sram_slave #(.MEM_AW(MEM_AW), .RESP_DELAY(2)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural SRAM: byte-lane writes, registered read, bench preload port.
    logic [31:0]       mem [0:(1<<MEM_AW)-1];
    logic              pre_we = 1'b0;
    logic [MEM_AW-1:0] pre_addr = '0;
    logic [31:0]       pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [MEM_AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [3:0] id, input logic [31:0] exp);
        int n;
        @(negedge clk);
        arvalid = 1'b1; araddr = addr; arid = id;
        #1;
        chk({tag, ".arready"}, 32'(arready), 32'd1);
        chk({tag, ".ram_addr"}, 32'(ram_addr), (addr >> 2) & 32'hFFFF);
        chk({tag, ".ram_en"}, 32'(ram_en), 32'd1);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            arvalid = 1'b0;
        end while (!rvalid && n < 50);
        chk({tag, ".latency"}, n, RD_LAT);
        chk({tag, ".rdata"}, rdata, exp);
        chk({tag, ".rid"}, 32'(rid), 32'(id));
        chk({tag, ".rlast_rresp"}, {29'd0, rlast, rresp}, 32'h4);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk({tag, ".rvalid_clr"}, 32'(rvalid), 32'd0);
        $display("read  %s addr=%h id=%0d data=%h lat=%0d", tag, addr, id, rdata, n);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [3:0] id,
                            input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        awvalid = 1'b1; awaddr = addr; awid = id;
        #1;
        chk({tag, ".awready"}, 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        chk({tag, ".wready"}, 32'(wready), 32'd1);
        wvalid = 1'b1; wdata = d; wstrb = s;
        #1;
        chk({tag, ".ram_en_wen"}, {27'd0, ram_en, ram_wen}, {27'd1, s});
        chk({tag, ".ram_waddr"}, 32'(ram_addr), (addr >> 2) & 32'hFFFF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            wvalid = 1'b0;
        end while (!bvalid && n < 50);
        chk({tag, ".latency"}, n, WR_LAT);
        chk({tag, ".bid"}, 32'(bid), 32'(id));
        chk({tag, ".bresp"}, 32'(bresp), 32'd0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk({tag, ".bvalid_clr"}, 32'(bvalid), 32'd0);
        $display("write %s addr=%h id=%0d data=%h strb=%b", tag, addr, id, d, s);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.outs", {28'd0, arready, awready, rvalid, bvalid}, 32'd0);
        chk("rst.ram_en", 32'(ram_en), 32'd0);
        chk("rst.rlast", 32'(rlast), 32'd1);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle.ready", {30'd0, awready, arready}, 32'd3);
        chk("idle.rdata", rdata, 32'd0);

        // Single read
        preload(16'h0010, 32'hDEADBEEF);
        preload(16'h0011, 32'hFFFFFFFF);
        preload(16'h0012, 32'h12345678);
        do_read("rd1", 32'h0000_0040, 4'd1, 32'hDEADBEEF);

        // Partial write then read-back
        do_write("wr_part", 32'h0000_0044, 4'd1, 32'h11223344, 4'b0101);
        do_read("rd_part", 32'h0000_0044, 4'd2, 32'hFF22FF44);

        // wstrb=0 still completes and changes nothing
        do_write("wr_nostrb", 32'h0000_0044, 4'd3, 32'h00000000, 4'b0000);
        do_read("rd_nostrb", 32'h0000_0044, 4'd3, 32'hFF22FF44);

        // Simultaneous AR and AW: write wins, read sees new data
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h0000_0040; awid = 4'd5;
        arvalid = 1'b1; araddr = 32'h0000_0040; arid = 4'd6;
        #1;
        chk("both.readys", {30'd0, awready, arready}, 32'd2);
        @(negedge clk);
        awvalid = 1'b0;
        chk("both.ar_blk_w", 32'(arready), 32'd0);
        wvalid = 1'b1; wdata = 32'hA5A5_0001; wstrb = 4'hF;
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 1; i < WR_LAT; i++) @(negedge clk);
        chk("both.bvalid", 32'(bvalid), 32'd1);
        chk("both.ar_blk_b", 32'(arready), 32'd0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("both.ar_after_b", 32'(arready), 32'd1);
        arvalid = 1'b0;
        do_read("both.rd", 32'h0000_0040, 4'd6, 32'hA5A5_0001);

        // Back-pressure: rready low for 5 cycles
        @(negedge clk);
        arvalid = 1'b1; araddr = 32'h0000_0044; arid = 4'd7;
        @(negedge clk);
        for (int i = 1; i < RD_LAT; i++) @(negedge clk);
        chk("bp.rvalid0", 32'(rvalid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.rvalid", 32'(rvalid), 32'd1);
            chk("bp.rdata", rdata, 32'hFF22FF44);
            chk("bp.rid", 32'(rid), 32'd7);
            chk("bp.arready", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0; arvalid = 1'b0;
        chk("bp.done", 32'(rvalid), 32'd0);
        $display("read  bp addr=00000044 held 5 cycles");

        // Reset while in WR_DATA drops the write
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h0000_0048; awid = 4'd9;
        @(negedge clk);
        awvalid = 1'b0;
        chk("rstmid.wready", 32'(wready), 32'd1);
        resetn = 1'b0;
        wvalid = 1'b1; wdata = 32'h0BAD_0BAD; wstrb = 4'hF;
        #1;
        chk("rstmid.ram_en_now", 32'(ram_en), 32'd0);
        @(negedge clk);
        chk("rstmid.outs", {26'd0, ram_en, wready, awready, arready, rvalid, bvalid}, 32'd0);
        chk("rstmid.bid", 32'(bid), 32'd0);
        resetn = 1'b1; wvalid = 1'b0;
        #1;
        chk("rstmid.awready", 32'(awready), 32'd1);
        $display("reset mid-write dropped");
        do_read("rstmid.rd", 32'h0000_0048, 4'd4, 32'h12345678);

        // Aliasing above MEM_AW+1
        do_write("alias.wr", 32'h0004_0008, 4'd2, 32'hCAFEF00D, 4'hF);
        do_read("alias.rd", 32'h0000_0008, 4'd2, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
